seg7_to_bin: RTL and testbench
==============================

# seg7_to_bin

Converts three active-low 7-segment digit codes (hundreds, tens, ones) back to a 7-bit binary value, the inverse of the team's binary-to-7-segment display encoder. It sits on the input side of the display/entry path and turns captured or test-driven segment patterns into the same 7-bit quantity the encoder consumes. The conversion is sequential: one decimal digit is accumulated per cycle behind valid/ready handshakes, and the block flags invalid codes and out-of-range results.

## Interface
- No parameters; widths are fixed by the 7-bit value domain (0–127) and the 3-digit display.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  three segment codes are presented.
- in_ready  out  1  block can accept codes; high only in IDLE.
- seg2, seg1, seg0  in  [0:6] each  hundreds/tens/ones codes, bit order 0..6, active-low.
- out_valid  out  1  result available; held until accepted.
- out_ready  in  1  consumer accepts result.
- x  out  [6:0]  binary result.
- err  out  1  at least one input code was not a legal digit.
- ovf  out  1  decimal value exceeded 127.

## Operation
- Legal codes (bits 0..6): 0=000_0001, 1=100_1111, 2=001_0010, 3=000_0110, 4=100_1100, 5=010_0100, 6=010_0000, 7=000_1111, 8=000_0000, 9=000_1100.
- Any other code, including blank 111_1111, is invalid.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid, capture the three codes, clear the 10-bit accumulator `acc`, and clear the err/ovf working flags. Go to ACC2.
  - ACC2, ACC1, ACC0: decode seg2, seg1, then seg0 in turn. Update `acc = acc*10 + digit`.
    - An invalid code contributes digit 0 and sets the sticky working error.
  - ACC0 → DONE: register the outputs.
    - err = working error.
    - ovf = (!err && acc > 127).
    - x = 0 if err, else acc[6:0] (modulo 128).
  - DONE: out_valid=1. When out_ready, go to IDLE.
- Arithmetic: `acc` is 10 bits wide (maximum 999), so it never wraps internally.
- x, err and ovf stay stable from DONE entry until the next DONE entry.
- Reset, asynchronous and valid mid-operation: state=IDLE, acc=0, x=0, err=0, ovf=0, out_valid=0. in_ready is high after release. A partially converted request is discarded.

## Timing
- in_ready is combinational from state (IDLE).
- Accept happens at edge E0. ACC states run on E1–E3. out_valid goes high after E3, i.e. 3 cycles after the accept edge.
- A handshake in DONE at E4 returns to IDLE. The next accept is at E5 at the earliest, giving 1 conversion per 5 cycles maximum throughput.
- out_ready held low: the block stays in DONE indefinitely. in_ready remains 0 and inputs are ignored.
- in_valid outside IDLE has no effect. Input codes need only be stable on the accept edge.

## Configuration
- BIN_SAT_EN defined: when ovf=1, x=127 (saturate).
- BIN_SAT_EN undefined: x=acc[6:0] (wrap).
- ovf and err behave identically in both builds. err always forces x=0.

## Structure
- Package seg7_pkg:
  - Segment code constants SEG_ZERO..SEG_NINE and SEG_BLANK, shared with the encoder.
  - FSM state enum {IDLE, ACC2, ACC1, ACC0, DONE}.
- Sub-module seg7_digit_dec: combinational, 7-bit code → 4-bit digit plus legal flag. One instance is muxed across the three captured codes by state.

## Test plan
- Codes 0,4,2 → after 3 cycles out_valid=1, x=42, err=0, ovf=0.
- Codes 1,2,7 → x=127, ovf=0. Codes 1,2,8 → ovf=1; x=0 without BIN_SAT_EN, x=127 with it.
- Codes 9,9,9 → ovf=1; x=103 (999 mod 128) without BIN_SAT_EN, 127 with it.
- seg1=111_1111 with seg2=0, seg0=5 → err=1, x=0, ovf=0.
- out_ready low for 10 cycles in DONE → x stable, in_ready=0, new in_valid ignored. out_ready high → IDLE next cycle, next accept 5 cycles after the previous one.
- rst_n low while in ACC1 → immediately out_valid=0, x=0, err=0. After release in_ready=1, and a fresh 1,0,0 request yields x=100.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment code constants, FSM states and accumulate helper
//
// Segment codes are active-low and indexed [0:6], so the leftmost literal bit
// is segment 0. The encoder and decoder share these constants.
//
// Contents:
//   SEG_ZERO..SEG_NINE, SEG_BLANK : legal digit codes and the blank pattern
//   ACC_W, X_MAX                  : accumulator width and largest in-range value
//   state_t                       : conversion FSM states
//   acc_step()                    : one decimal accumulation step, acc*10 + digit
package seg7_pkg;

    localparam logic [0:6] SEG_ZERO  = 7'b000_0001;
    localparam logic [0:6] SEG_ONE   = 7'b100_1111;
    localparam logic [0:6] SEG_TWO   = 7'b001_0010;
    localparam logic [0:6] SEG_THREE = 7'b000_0110;
    localparam logic [0:6] SEG_FOUR  = 7'b100_1100;
    localparam logic [0:6] SEG_FIVE  = 7'b010_0100;
    localparam logic [0:6] SEG_SIX   = 7'b010_0000;
    localparam logic [0:6] SEG_SEVEN = 7'b000_1111;
    localparam logic [0:6] SEG_EIGHT = 7'b000_0000;
    localparam logic [0:6] SEG_NINE  = 7'b000_1100;
    localparam logic [0:6] SEG_BLANK = 7'b111_1111;

    // Three decimal digits reach at most 999, which fits in 10 bits.
    localparam int unsigned ACC_W = 10;
    localparam logic [ACC_W-1:0] X_MAX = 10'd127;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC2 = 3'd1,
        ACC1 = 3'd2,
        ACC0 = 3'd3,
        DONE = 3'd4
    } state_t;

    // The previous accumulator value is at most 99 when this is applied, so
    // the result never exceeds 999 and cannot wrap.
    function automatic logic [ACC_W-1:0] acc_step(
        input logic [ACC_W-1:0] acc,
        input logic [3:0]       digit
    );
        logic [ACC_W-1:0] times_ten;
        times_ten = {acc[ACC_W-4:0], 3'b000} + {acc[ACC_W-2:0], 1'b0};
        return times_ten + {{(ACC_W-4){1'b0}}, digit};
    endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// rtl/seg7_digit_dec.sv - combinational active-low 7-segment code to decimal digit decoder
//
// Ports:
//   i_code  [0:6] active-low segment code, segment 0 leftmost
//   o_digit [3:0] decoded digit 0..9; 0 when the code is not a legal digit
//   o_legal       1 when i_code is one of the ten digit patterns
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [0:6] i_code,
    output logic [3:0] o_digit,
    output logic       o_legal
);

    // Illegal codes (blank included) fall through to the default and
    // contribute a zero digit, so the accumulator stays well defined.
    always_comb begin
        o_digit = 4'd0;
        o_legal = 1'b1;
        case (i_code)
            SEG_ZERO:  o_digit = 4'd0;
            SEG_ONE:   o_digit = 4'd1;
            SEG_TWO:   o_digit = 4'd2;
            SEG_THREE: o_digit = 4'd3;
            SEG_FOUR:  o_digit = 4'd4;
            SEG_FIVE:  o_digit = 4'd5;
            SEG_SIX:   o_digit = 4'd6;
            SEG_SEVEN: o_digit = 4'd7;
            SEG_EIGHT: o_digit = 4'd8;
            SEG_NINE:  o_digit = 4'd9;
            default: begin
                o_digit = 4'd0;
                o_legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg7_to_bin.sv
// rtl/seg7_to_bin.sv - sequential three-digit 7-segment to 7-bit binary converter
//
// Captures hundreds/tens/ones codes on an in_valid/in_ready handshake, then
// accumulates one digit per cycle (hundreds first) and presents the result
// behind an out_valid/out_ready handshake.
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   in_valid         three segment codes are presented
//   in_ready         high only in IDLE
//   seg2/seg1/seg0   [0:6] hundreds/tens/ones codes, active-low
//   out_valid        result available, held until out_ready
//   out_ready        consumer accepts result
//   x      [6:0]     binary result (0 on error)
//   err              at least one code was not a legal digit
//   ovf              legal decimal value exceeded 127
//
// Build option: BIN_SAT_EN - when defined, an overflowing result saturates
// x to 127; otherwise x is the value modulo 128.
module seg7_to_bin
    import seg7_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [0:6] seg2,
    input  logic [0:6] seg1,
    input  logic [0:6] seg0,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:0] x,
    output logic       err,
    output logic       ovf
);

    state_t           r_state;
    state_t           w_state_next;

    logic [0:6]       r_seg2;
    logic [0:6]       r_seg1;
    logic [0:6]       r_seg0;
    logic [ACC_W-1:0] r_acc;
    logic             r_err_work;

    logic [6:0]       r_x;
    logic             r_err;
    logic             r_ovf;

    logic [0:6]       w_code;
    logic [3:0]       w_digit;
    logic             w_legal;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_err_next;
    logic             w_ovf_next;
    logic [6:0]       w_x_next;
    logic             w_accept;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = ACC2;
            ACC2:                   w_state_next = ACC1;
            ACC1:                   w_state_next = ACC0;
            ACC0:                   w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_ready && in_valid;

    // ------------------------------------------------------------------
    // Digit decode: a single decoder is time-shared across the captured
    // codes, selected by which accumulation state is active.
    // ------------------------------------------------------------------
    always_comb begin
        w_code = r_seg0;
        case (r_state)
            ACC2:    w_code = r_seg2;
            ACC1:    w_code = r_seg1;
            default: w_code = r_seg0;
        endcase
    end

    seg7_digit_dec u_digit_dec (
        .i_code  (w_code),
        .o_digit (w_digit),
        .o_legal (w_legal)
    );

    // ------------------------------------------------------------------
    // Accumulation and result formation. The result registers are loaded
    // from the same-cycle accumulator update in ACC0, so the final digit
    // is included without an extra cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_acc_next = acc_step(r_acc, w_digit);
        w_err_next = r_err_work | ~w_legal;
        // An error suppresses overflow: the value is meaningless then.
        w_ovf_next = !w_err_next && (w_acc_next > X_MAX);

        if (w_err_next) begin
            w_x_next = 7'd0;
        end
`ifdef BIN_SAT_EN
        else if (w_ovf_next) begin
            w_x_next = 7'd127;
        end
`endif
        else begin
            w_x_next = w_acc_next[6:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg2     <= SEG_BLANK;
            r_seg1     <= SEG_BLANK;
            r_seg0     <= SEG_BLANK;
            r_acc      <= '0;
            r_err_work <= 1'b0;
        end else begin
            if (w_accept) begin
                r_seg2     <= seg2;
                r_seg1     <= seg1;
                r_seg0     <= seg0;
                r_acc      <= '0;
                r_err_work <= 1'b0;
            end else if (r_state == ACC2 || r_state == ACC1 || r_state == ACC0) begin
                r_acc      <= w_acc_next;
                r_err_work <= w_err_next;
            end
        end
    end

    // Outputs hold from one DONE entry to the next; only ACC0 reloads them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x   <= 7'd0;
            r_err <= 1'b0;
            r_ovf <= 1'b0;
        end else if (r_state == ACC0) begin
            r_x   <= w_x_next;
            r_err <= w_err_next;
            r_ovf <= w_ovf_next;
        end
    end

    assign x   = r_x;
    assign err = r_err;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_seg7_to_bin.sv
// tb/tb_seg7_to_bin.sv - self-checking bench for seg7_to_bin (vectors, random model, corner sequences)
module tb_seg7_to_bin;

`ifdef BIN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [0:6] seg2 = 7'b111_1111;
    logic [0:6] seg1 = 7'b111_1111;
    logic [0:6] seg0 = 7'b111_1111;
    logic       in_ready;
    logic       out_valid;
    logic [6:0] x;
    logic       err;
    logic       ovf;

    seg7_to_bin dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .seg2      (seg2),
        .seg1      (seg1),
        .seg0      (seg0),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .err       (err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [0:6] code_tab [10];
    logic [0:6] blank;

    // Accept-edge log: cycle numbers where in_valid && in_ready at a rising edge.
    int cyc = 0;
    int acc_q[$];
    always @(posedge clk) begin
        if (in_valid && in_ready) acc_q.push_back(cyc);
        cyc = cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: look each code up in the digit table, form the decimal
    // value arithmetically, then apply the error/overflow/saturation rules.
    task automatic model(input logic [0:6] c2, input logic [0:6] c1, input logic [0:6] c0,
                         output int ex, output int eerr, output int eovf);
        logic [0:6] c [3];
        int d [3];
        int val;
        bit bad;
        c[0] = c2; c[1] = c1; c[2] = c0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d[i] = -1;
            for (int k = 0; k < 10; k++) if (c[i] == code_tab[k]) d[i] = k;
            if (d[i] < 0) begin
                bad = 1'b1;
                d[i] = 0;
            end
        end
        val  = 100 * d[0] + 10 * d[1] + d[2];
        eerr = bad ? 1 : 0;
        eovf = (!bad && val > 127) ? 1 : 0;
        if (bad)               ex = 0;
        else if (eovf && SAT)  ex = 127;
        else                   ex = val % 128;
    endtask

    // One conversion: handshake in, measure latency, read result, optionally
    // hold off the consumer for `hold` cycles while offering new input, then accept.
    task automatic run_conv(input logic [0:6] c2, input logic [0:6] c1, input logic [0:6] c0,
                            input int hold, input string tag,
                            output int rx, output int rerr, output int rovf, output int lat);
        int n;
        bit held_ok;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready_idle"}, in_ready, 1);
        seg2 = c2; seg1 = c1; seg0 = c0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seg2 = 7'($urandom); seg1 = 7'($urandom); seg0 = 7'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rx = x; rerr = err; rovf = ovf;
        if (hold > 0) begin
            held_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                in_valid = 1'b1;
                seg2 = code_tab[$urandom_range(9)];
                seg1 = code_tab[$urandom_range(9)];
                seg0 = code_tab[$urandom_range(9)];
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || int'(x) != rx
                    || int'(err) != rerr || int'(ovf) != rovf) held_ok = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check({tag, "_hold_stable"}, held_ok, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ready_after_done"}, in_ready, 1);
        check({tag, "_valid_drop"}, out_valid, 0);
    endtask

    typedef struct {
        logic [0:6] c2;
        logic [0:6] c1;
        logic [0:6] c0;
        int         ex;
        int         eerr;
        int         eovf;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int rx, rerr, rovf, lat, ex, eerr, eovf, n;
        logic [0:6] r [3];

        code_tab[0] = 7'b000_0001; code_tab[1] = 7'b100_1111;
        code_tab[2] = 7'b001_0010; code_tab[3] = 7'b000_0110;
        code_tab[4] = 7'b100_1100; code_tab[5] = 7'b010_0100;
        code_tab[6] = 7'b010_0000; code_tab[7] = 7'b000_1111;
        code_tab[8] = 7'b000_0000; code_tab[9] = 7'b000_1100;
        blank = 7'b111_1111;

        vecs[0] = '{code_tab[0], code_tab[4], code_tab[2], 42, 0, 0};
        vecs[1] = '{code_tab[1], code_tab[2], code_tab[7], 127, 0, 0};
        vecs[2] = '{code_tab[1], code_tab[2], code_tab[8], SAT ? 127 : 0, 0, 1};
        vecs[3] = '{code_tab[9], code_tab[9], code_tab[9], SAT ? 127 : 103, 0, 1};
        vecs[4] = '{code_tab[0], blank, code_tab[5], 0, 1, 0};
        vecs[5] = '{code_tab[0], code_tab[0], code_tab[0], 0, 0, 0};
        vecs[6] = '{blank, blank, blank, 0, 1, 0};
        vecs[7] = '{code_tab[1], code_tab[0], code_tab[0], 100, 0, 0};
        vecs[8] = '{code_tab[9], code_tab[9], blank, 0, 1, 0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_x", x, 0);
        check("rst_err", err, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i].c2, vecs[i].c1, vecs[i].c0, 0, $sformatf("vec%0d", i), rx, rerr, rovf, lat);
            check($sformatf("vec%0d_latency", i), lat, 3);
            check($sformatf("vec%0d_x", i), rx, vecs[i].ex);
            check($sformatf("vec%0d_err", i), rerr, vecs[i].eerr);
            check($sformatf("vec%0d_ovf", i), rovf, vecs[i].eovf);
        end

        // Consumer stalls 10 cycles in DONE
        run_conv(code_tab[0], code_tab[4], code_tab[2], 10, "hold", rx, rerr, rovf, lat);
        check("hold_x", rx, 42);

        // Back-to-back throughput: one accept every 5 cycles
        @(negedge clk);
        acc_q.delete();
        seg2 = code_tab[0]; seg1 = code_tab[1]; seg0 = code_tab[2];
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (acc_q.size() < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("tput_accepts", acc_q.size(), 3);
        if (acc_q.size() >= 3) begin
            check("tput_gap01", acc_q[1] - acc_q[0], 5);
            check("tput_gap12", acc_q[2] - acc_q[1], 5);
        end
        repeat (8) @(negedge clk);
        out_ready = 1'b0;
        check("tput_x", x, 12);

        // Random codes against the model
        for (int t = 0; t < 40; t++) begin
            for (int j = 0; j < 3; j++) begin
                if ($urandom_range(9) < 8) r[j] = code_tab[$urandom_range(9)];
                else                       r[j] = 7'($urandom);
            end
            model(r[0], r[1], r[2], ex, eerr, eovf);
            run_conv(r[0], r[1], r[2], 0, $sformatf("rnd%0d", t), rx, rerr, rovf, lat);
            check($sformatf("rnd%0d_x", t), rx, ex);
            check($sformatf("rnd%0d_err", t), rerr, eerr);
            check($sformatf("rnd%0d_ovf", t), rovf, eovf);
        end

        // Asynchronous reset while in ACC1
        run_conv(code_tab[1], code_tab[2], code_tab[7], 0, "pre_rst", rx, rerr, rovf, lat);
        check("pre_rst_x", rx, 127);
        @(negedge clk);
        seg2 = code_tab[9]; seg1 = code_tab[9]; seg0 = code_tab[9];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_x", x, 0);
        check("arst_err", err, 0);
        check("arst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        run_conv(code_tab[1], code_tab[0], code_tab[0], 0, "post_rst", rx, rerr, rovf, lat);
        check("post_rst_latency", lat, 3);
        check("post_rst_x", rx, 100);
        check("post_rst_err", rerr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
